// File: rtl/sr_ff_bank_pkg.sv
// Shared definitions for the SR flip-flop bank: conflict policies and the
// single-cell next-state function used by both the cells and reference models.
package sr_bank_pkg;

  localparam int CM_HOLD   = 0;
  localparam int CM_SET    = 1;
  localparam int CM_RST    = 2;
  localparam int CM_TOGGLE = 3;

  localparam int N_MAX = 32;

  function automatic bit mode_valid(input int mode);
    return (mode >= CM_HOLD) && (mode <= CM_TOGGLE);
  endfunction

  // S and R are already normalised to active-high here.
  function automatic logic next_q(input logic q, input logic s, input logic r,
                                  input int mode);
    logic nq;
    nq = q;
    unique case ({s, r})
      2'b00: nq = q;
      2'b10: nq = 1'b1;
      2'b01: nq = 1'b0;
      default: begin
        case (mode)
          CM_SET:    nq = 1'b1;
          CM_RST:    nq = 1'b0;
          CM_TOGGLE: nq = ~q;
          default:   nq = q;
        endcase
      end
    endcase
    return nq;
  endfunction

endpackage

// File: rtl/sr_ff_bank_if.sv
// Bundle of control inputs and status outputs for the SR bank.
// The slave modport is the bank itself; master is whoever drives events.
interface sr_ff_bank_if #(
  parameter int N     = 8,
  parameter int CNT_W = 8
);
  logic             en;
  logic [N-1:0]     s;
  logic [N-1:0]     r;
  logic             err_clr;
  logic [N-1:0]     q;
  logic [N-1:0]     qn;
  logic [N-1:0]     illegal;
  logic [CNT_W-1:0] err_cnt;
  logic             err_any;

  modport slave (
    input  en, s, r, err_clr,
    output q, qn, illegal, err_cnt, err_any
  );

  modport master (
    output en, s, r, err_clr,
    input  q, qn, illegal, err_cnt, err_any
  );
endinterface

// File: rtl/sr_ff_bank_cell.sv
// One edge-triggered SR storage bit with a registered conflict flag.
// Inputs arrive already normalised to active-high.
module sr_ff_cell
  import sr_bank_pkg::*;
#(
  parameter int CONFLICT_MODE = CM_HOLD,
  parameter bit RST_VAL       = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_clr,
  input  logic i_s,
  input  logic i_r,
  output logic o_q,
  output logic o_illegal
);

  logic r_q;
  logic r_illegal;
  logic w_conflict;

  assign w_conflict = i_s & i_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q       <= RST_VAL;
      r_illegal <= 1'b0;
    end else begin
      if (i_en) begin
        r_q <= next_q(r_q, i_s, i_r, CONFLICT_MODE);
      end
      // A clear wins over a fresh conflict on the same edge.
      if (i_clr) begin
        r_illegal <= 1'b0;
      end else if (i_en) begin
        r_illegal <= w_conflict;
      end
    end
  end

  assign o_q       = r_q;
  assign o_illegal = r_illegal;

endmodule

// File: rtl/sr_ff_bank.sv
// Bank of N independent SR flip-flops with input polarity normalisation,
// per-channel conflict flags and a saturating conflict-edge counter.
module sr_ff_bank
  import sr_bank_pkg::*;
#(
  parameter int N             = 8,
  parameter bit ACTIVE_LOW    = 1'b1,
  parameter int CONFLICT_MODE = CM_HOLD,
  parameter bit RST_VAL       = 1'b0,
  parameter int CNT_W         = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  sr_ff_bank_if.slave    bus
);

  if (!mode_valid(CONFLICT_MODE)) begin : g_bad_mode
    $fatal(1, "sr_ff_bank: CONFLICT_MODE %0d is not a defined policy", CONFLICT_MODE);
  end
  if (N < 1 || N > N_MAX) begin : g_bad_n
    $fatal(1, "sr_ff_bank: N %0d out of range 1..%0d", N, N_MAX);
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $fatal(1, "sr_ff_bank: CNT_W must be at least 1");
  end

  logic [N-1:0]     w_s;
  logic [N-1:0]     w_r;
  logic [N-1:0]     w_q;
  logic [N-1:0]     w_illegal;
  logic             w_hit;
  logic             w_sat;
  logic [CNT_W-1:0] r_err_cnt;

  assign w_s = ACTIVE_LOW ? ~bus.s : bus.s;
  assign w_r = ACTIVE_LOW ? ~bus.r : bus.r;

  for (genvar i = 0; i < N; i++) begin : g_cell
    sr_ff_cell #(
      .CONFLICT_MODE (CONFLICT_MODE),
      .RST_VAL       (RST_VAL)
    ) u_cell (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_en      (bus.en),
      .i_clr     (bus.err_clr),
      .i_s       (w_s[i]),
      .i_r       (w_r[i]),
      .o_q       (w_q[i]),
      .o_illegal (w_illegal[i])
    );
  end

  // One count per enabled edge, however many channels conflict at once.
  assign w_hit = bus.en & (|(w_s & w_r));
  assign w_sat = &r_err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (bus.err_clr) begin
      r_err_cnt <= '0;
    end else if (w_hit && !w_sat) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign bus.q       = w_q;
  assign bus.qn      = ~w_q;
  assign bus.illegal = w_illegal;
  assign bus.err_cnt = r_err_cnt;
  assign bus.err_any = |w_illegal;

endmodule

// File: tb/tb_sr_ff_bank.sv
// Bench for sr_ff_bank: an active-low N=4 build driven from a vector table,
// plus four active-high N=8 builds (one per conflict mode) tracked by a scoreboard.
module tb_sr_ff_bank;
  import sr_bank_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // active-low N=4 build
  logic       al_en, al_clr;
  logic [3:0] al_s, al_r;
  sr_ff_bank_if #(.N(4), .CNT_W(8)) al_if ();
  assign al_if.en      = al_en;
  assign al_if.s       = al_s;
  assign al_if.r       = al_r;
  assign al_if.err_clr = al_clr;
  sr_ff_bank #(.N(4), .ACTIVE_LOW(1'b1), .CONFLICT_MODE(CM_HOLD), .RST_VAL(1'b0), .CNT_W(8))
    u_al (.clk(clk), .rst_n(rst_n), .bus(al_if.slave));

  // four active-high N=8, CNT_W=3 builds sharing stimulus
  logic       en, clr;
  logic [7:0] s, r;
  logic [7:0] q_m [4];
  logic [7:0] qn_m [4];
  logic [7:0] ill_m [4];
  logic [2:0] cnt_m [4];
  logic       any_m [4];

  for (genvar m = 0; m < 4; m++) begin : g_mode
    sr_ff_bank_if #(.N(8), .CNT_W(3)) mif ();
    assign mif.en      = en;
    assign mif.s       = s;
    assign mif.r       = r;
    assign mif.err_clr = clr;
    sr_ff_bank #(.N(8), .ACTIVE_LOW(1'b0), .CONFLICT_MODE(m), .RST_VAL(1'b0), .CNT_W(3))
      u_dut (.clk(clk), .rst_n(rst_n), .bus(mif.slave));
    assign q_m[m]   = mif.q;
    assign qn_m[m]  = mif.qn;
    assign ill_m[m] = mif.illegal;
    assign cnt_m[m] = mif.err_cnt;
    assign any_m[m] = mif.err_any;
  end

  // reference model and scoreboard
  logic [7:0] mq [4];
  logic [7:0] mill [4];
  logic [2:0] mcnt [4];

  typedef struct packed {
    logic [3:0][7:0] q;
    logic [3:0][7:0] ill;
    logic [3:0][2:0] cnt;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic       en;
    logic [3:0] s;
    logic [3:0] r;
    logic       clr;
    logic [3:0] q;
    logic [3:0] ill;
    logic [7:0] cnt;
  } vec_t;
  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 4; m++) begin
      mq[m] = '0; mill[m] = '0; mcnt[m] = '0;
    end
  endtask

  task automatic model_step(input logic e, input logic [7:0] ss, input logic [7:0] rr,
                            input logic c);
    exp_t x;
    for (int m = 0; m < 4; m++) begin
      if (e) begin
        for (int b = 0; b < 8; b++) mq[m][b] = next_q(mq[m][b], ss[b], rr[b], m);
      end
      if (c) begin
        mill[m] = '0;
        mcnt[m] = '0;
      end else if (e) begin
        mill[m] = ss & rr;
        if ((|(ss & rr)) && mcnt[m] != 3'd7) mcnt[m] = mcnt[m] + 3'd1;
      end
      x.q[m] = mq[m]; x.ill[m] = mill[m]; x.cnt[m] = mcnt[m];
    end
    sb.push_back(x);
  endtask

  task automatic compare_pop();
    exp_t x;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    x = sb.pop_front();
    for (int m = 0; m < 4; m++) begin
      chk($sformatf("m%0d_q", m),   {24'd0, q_m[m]},   {24'd0, x.q[m]});
      chk($sformatf("m%0d_qn", m),  {24'd0, qn_m[m]},  {24'd0, ~x.q[m]});
      chk($sformatf("m%0d_ill", m), {24'd0, ill_m[m]}, {24'd0, x.ill[m]});
      chk($sformatf("m%0d_cnt", m), {29'd0, cnt_m[m]}, {29'd0, x.cnt[m]});
      chk($sformatf("m%0d_any", m), {31'd0, any_m[m]}, {31'd0, |x.ill[m]});
    end
  endtask

  task automatic step(input logic e, input logic [7:0] ss, input logic [7:0] rr,
                      input logic c);
    en = e; s = ss; r = rr; clr = c;
    model_step(e, ss, rr, c);
    @(posedge clk);
    #1;
    compare_pop();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] exp1;
    logic [3:0] exp2;
    logic [7:0] snap [4];
    logic [2:0] snapc [4];

    en = 0; s = '0; r = '0; clr = 0;
    al_en = 0; al_s = 4'hF; al_r = 4'hF; al_clr = 0;
    model_reset();

    // {en, s, r, clr} -> {q, illegal, err_cnt} on the active-low build
    tbl[0] = '{1'b1, 4'b1110, 4'b1111, 1'b0, 4'b0001, 4'b0000, 8'd0};
    tbl[1] = '{1'b1, 4'b1111, 4'b1110, 1'b0, 4'b0000, 4'b0000, 8'd0};
    tbl[2] = '{1'b1, 4'b1101, 4'b1101, 1'b0, 4'b0000, 4'b0010, 8'd1};
    tbl[3] = '{1'b1, 4'b0000, 4'b1111, 1'b0, 4'b1111, 4'b0000, 8'd1};
    tbl[4] = '{1'b0, 4'b1111, 4'b0000, 1'b0, 4'b1111, 4'b0000, 8'd1};
    tbl[5] = '{1'b1, 4'b1111, 4'b0101, 1'b0, 4'b0101, 4'b0000, 8'd1};
    tbl[6] = '{1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0101, 4'b1111, 8'd2};
    tbl[7] = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0101, 4'b0000, 8'd0};
    tbl[8] = '{1'b1, 4'b1110, 4'b1110, 1'b0, 4'b0101, 4'b0001, 8'd1};
    tbl[9] = '{1'b1, 4'b1111, 4'b1111, 1'b0, 4'b0101, 4'b0000, 8'd1};

    repeat (2) @(posedge clk);
    #1;
    chk("al_rst_q", {28'd0, al_if.q}, 32'h0);
    chk("al_rst_qn", {28'd0, al_if.qn}, 32'hF);
    chk("al_rst_ill", {28'd0, al_if.illegal}, 32'h0);
    chk("al_rst_cnt", {24'd0, al_if.err_cnt}, 32'h0);
    for (int m = 0; m < 4; m++) begin
      chk("m_rst_q", {24'd0, q_m[m]}, 32'h0);
      chk("m_rst_qn", {24'd0, qn_m[m]}, 32'hFF);
      chk("m_rst_cnt", {29'd0, cnt_m[m]}, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      al_en = tbl[i].en; al_s = tbl[i].s; al_r = tbl[i].r; al_clr = tbl[i].clr;
      @(posedge clk);
      #1;
      chk($sformatf("al_v%0d_q", i),   {28'd0, al_if.q},       {28'd0, tbl[i].q});
      chk($sformatf("al_v%0d_qn", i),  {28'd0, al_if.qn},      {28'd0, ~tbl[i].q});
      chk($sformatf("al_v%0d_ill", i), {28'd0, al_if.illegal}, {28'd0, tbl[i].ill});
      chk($sformatf("al_v%0d_cnt", i), {24'd0, al_if.err_cnt}, {24'd0, tbl[i].cnt});
      chk($sformatf("al_v%0d_any", i), {31'd0, al_if.err_any}, {31'd0, |tbl[i].ill});
    end
    al_en = 0;

    // conflict policies on channel 0 starting from q=1
    exp1 = 4'b0011;
    exp2 = 4'b1011;
    step(1, 8'h01, 8'h00, 0);
    step(1, 8'h01, 8'h01, 0);
    for (int m = 0; m < 4; m++) begin
      chk($sformatf("cm%0d_edge1", m), {31'd0, q_m[m][0]}, {31'd0, exp1[m]});
      chk($sformatf("cm%0d_ill", m), {31'd0, ill_m[m][0]}, 32'd1);
      chk($sformatf("cm%0d_cnt1", m), {29'd0, cnt_m[m]}, 32'd1);
    end
    step(1, 8'h01, 8'h01, 0);
    for (int m = 0; m < 4; m++) begin
      chk($sformatf("cm%0d_edge2", m), {31'd0, q_m[m][0]}, {31'd0, exp2[m]});
      chk($sformatf("cm%0d_cnt2", m), {29'd0, cnt_m[m]}, 32'd2);
    end

    // enable gating
    for (int m = 0; m < 4; m++) begin
      snap[m] = q_m[m]; snapc[m] = cnt_m[m];
    end
    repeat (5) step(0, 8'hFF, 8'hFF, 0);
    for (int m = 0; m < 4; m++) begin
      chk("gate_q", {24'd0, q_m[m]}, {24'd0, snap[m]});
      chk("gate_cnt", {29'd0, cnt_m[m]}, {29'd0, snapc[m]});
    end
    step(1, 8'hFF, 8'h00, 0);
    for (int m = 0; m < 4; m++) chk("gate_release_q", {24'd0, q_m[m]}, 32'hFF);

    // saturation and clear-over-increment
    step(0, 8'h00, 8'h00, 1);
    for (int k = 1; k <= 10; k++) begin
      step(1, 8'h03, 8'h03, 0);
      for (int m = 0; m < 4; m++)
        chk($sformatf("sat_k%0d", k), {29'd0, cnt_m[m]}, (k > 7) ? 32'd7 : k);
    end
    step(1, 8'h03, 8'h03, 1);
    for (int m = 0; m < 4; m++) begin
      chk("clr_cnt", {29'd0, cnt_m[m]}, 32'd0);
      chk("clr_ill", {24'd0, ill_m[m]}, 32'd0);
    end
    step(1, 8'h03, 8'h03, 0);
    for (int m = 0; m < 4; m++) chk("clr_resume", {29'd0, cnt_m[m]}, 32'd1);

    // asynchronous reset between edges
    step(1, 8'hA5, 8'h5A, 0);
    for (int m = 0; m < 4; m++) chk("pre_rst_q", {24'd0, q_m[m]}, 32'hA5);
    #2;
    rst_n = 1'b0;
    #1;
    for (int m = 0; m < 4; m++) begin
      chk("async_rst_q", {24'd0, q_m[m]}, 32'h0);
      chk("async_rst_qn", {24'd0, qn_m[m]}, 32'hFF);
      chk("async_rst_cnt", {29'd0, cnt_m[m]}, 32'h0);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 8'h0F, 8'h00, 0);
    for (int m = 0; m < 4; m++) chk("post_rst_q", {24'd0, q_m[m]}, 32'h0F);

    // random traffic
    for (int i = 0; i < 10000; i++) begin
      step($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom),
           $urandom_range(0, 15) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sr_ff_bank.md
Name: sr_ff_bank

Overview:
- Parametrised, edge-triggered bank of N SR storage cells. It replaces single-bit level-sensitive SR latches in control paths.
- Each cell has a defined policy for the forbidden S/R combination and optional active-low inputs.
- Per-channel illegal-combination flags and a saturating error counter are provided for debug and status registers.
- Sits between raw set/clear event sources (IRQ lines, handshake strobes) and status-register readback logic.

Parameters:
- N, 8, number of independent SR channels (1..32).
- ACTIVE_LOW, 1, 1 = s/r asserted when 0 (NAND-style); 0 = asserted when 1.
- CONFLICT_MODE, 0, policy when both asserted: 0 hold, 1 set-dominant, 2 reset-dominant, 3 toggle (JK-like).
- RST_VAL, 0, N-bit reset value of q (replicated scalar 0 or 1).
- CNT_W, 8, width of the error counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  clock enable; cells update only when en=1.
- s  input  N  per-channel set, polarity per ACTIVE_LOW.
- r  input  N  per-channel reset, polarity per ACTIVE_LOW.
- err_clr  input  1  synchronous clear of err_cnt and illegal.
- q  output  N  stored state.
- qn  output  N  ~q, always the exact complement, never X.
- illegal  output  N  registered: channel saw both asserted on its last enabled edge.
- err_cnt  output  CNT_W  saturating count of enabled edges where any channel was illegal.
- err_any  output  1  OR-reduction of illegal, combinational from the register.

Behaviour:
- Reset (rst_n=0, asynchronous): q=RST_VAL, qn=~RST_VAL, illegal=0, err_cnt=0. Outputs stay fixed while reset is held. Release takes effect on the next rising edge.
- Internal normalisation: S = ACTIVE_LOW ? ~s : s; R likewise.
- Per channel, on a rising edge with en=1 (one-cycle latency, q visible after the edge):
  - S=0,R=0: q holds.
  - S=1,R=0: q=1.
  - S=0,R=1: q=0.
  - S=1,R=1: the CONFLICT_MODE action applies (hold / 1 / 0 / ~q), and illegal[i]=1.
- When a channel is not illegal on an enabled edge, illegal[i]=0. Flags reflect only the most recent enabled edge.
- en=0: q, illegal and err_cnt all hold. Inputs are ignored and nothing is counted.
- err_cnt increments by exactly 1 per enabled edge where |(S&R) is true, regardless of how many channels conflict.
- err_cnt saturates at 2^CNT_W-1 and never wraps.
- err_clr=1 at an edge (independent of en): err_cnt=0 and illegal=0 on that edge, overriding any increment. q still updates normally if en=1.
- Outputs never go X or Z. In particular, 00 in active-low mode is handled as a legal-or-policy state, never as an unknown.
- Reset asserted mid-operation aborts everything immediately. The first enabled edge after release evaluates from RST_VAL.
- Channels are fully independent. There is no cross-channel priority.
- Illegal CONFLICT_MODE values (elaboration time): fatal error.

Decomposition:
- Package sr_bank_pkg holds:
  - localparams CM_HOLD=0, CM_SET=1, CM_RST=2, CM_TOGGLE=3;
  - a function next_q(q, S, R, mode) shared by RTL and the scoreboard.
- Sub-module sr_ff_cell is a one-bit cell (clk, rst_n, en, S, R → q, illegal), instantiated N times via generate.
- Polarity normalisation, err_cnt and err_any live in the top level.

Test Plan:
- Reset and polarity: N=4, ACTIVE_LOW=1, RST_VAL=0, rst_n low 2 cycles then high, s=r=4'hF → q=0, qn=4'hF, illegal=0, err_cnt=0. Then s=4'b1110, r=4'hF, en=1 → after 1 edge q=4'b0001. Then r=4'b1110, s=4'hF → q=4'b0000.
- Conflict modes: apply S=R=1 (active-high build) on channel 0 with q=1, one bench per mode → q after edge: hold=1, set=1, reset=0, toggle=0, then 1 after a second edge. illegal[0]=1 and err_cnt increments by 1 per edge.
- Enable gating: en=0 with set on all channels for 5 edges → q, illegal and err_cnt unchanged. en=1 → update on the first edge.
- Counter: CNT_W=3, hold a conflict on 2 channels for 10 enabled edges → err_cnt reads 1..7 and then stays 7. err_clr with an active conflict → err_cnt=0 and illegal=0 on that edge, and counting resumes at 1 on the next edge.
- Async reset mid-run: q=8'hA5, assert rst_n between edges → q=RST_VAL immediately, with no clock edge needed. Release, then the first enabled edge uses the inputs from RST_VAL.
- Random: 10k cycles of random s/r/en/err_clr with N=8, all 4 modes → q, qn, illegal and err_cnt match the sr_bank_pkg::next_q reference model each cycle, and qn==~q always.
